// File: rtl/trace_pkg.sv
// Shared types and rd_data field layout for the execution trace buffer.
package trace_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      POST  = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Entry layout, MSB first: {pc, inst, result, reg_write, mem_read, mem_write}
   localparam int MEM_WRITE_BIT = 0;
   localparam int MEM_READ_BIT  = 1;
   localparam int REG_WRITE_BIT = 2;
   localparam int RESULT_LSB    = 3;

   function automatic int ENTRY_W(input int data_w);
      return 3 * data_w + 3;
   endfunction

   function automatic int INST_LSB(input int data_w);
      return data_w + 3;
   endfunction

   function automatic int PC_LSB(input int data_w);
      return 2 * data_w + 3;
   endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: register array, one synchronous write port, asynchronous read.
module trace_ram
   import trace_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = ENTRY_W(8)
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/trace_buffer.sv
// Circular execution-trace capture with PC-match trigger, post-trigger window
// and oldest-first valid/ready drain.
module trace_buffer
   import trace_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 16,
   parameter int POST_TRIG = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic [DATA_W-1:0]          pc,
   input  logic [DATA_W-1:0]          inst,
   input  logic [DATA_W-1:0]          result,
   input  logic                       reg_write,
   input  logic                       mem_read,
   input  logic                       mem_write,
   input  logic                       arm,
   input  logic                       stop,
   input  logic                       trig_en,
   input  logic [DATA_W-1:0]          trig_pc,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [ENTRY_W(DATA_W)-1:0] rd_data,
   output logic                       busy,
   output logic                       triggered,
   output logic                       wrapped
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int EW = ENTRY_W(DATA_W);

   state_t          state_reg, state_next;
   logic [AW-1:0]   wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0]   count_reg, count_next, post_cnt_reg, post_cnt_next;
   logic            triggered_reg, triggered_next, wrapped_reg, wrapped_next;
   logic            capture, trig_hit, full, pop;
   logic [EW-1:0]   wr_entry, rd_entry;

   assign capture  = (state_reg == ARMED || state_reg == POST) && enable;
   assign trig_hit = (state_reg == ARMED) && capture && trig_en && (pc == trig_pc);
   assign full     = (count_reg == CW'(DEPTH));
   assign pop      = rd_valid && rd_ready;

   always_comb begin
      wr_entry = '0;
      wr_entry[PC_LSB(DATA_W)   +: DATA_W] = pc;
      wr_entry[INST_LSB(DATA_W) +: DATA_W] = inst;
      wr_entry[RESULT_LSB       +: DATA_W] = result;
      wr_entry[REG_WRITE_BIT]              = reg_write;
      wr_entry[MEM_READ_BIT]               = mem_read;
      wr_entry[MEM_WRITE_BIT]              = mem_write;
   end

   trace_ram #(.DEPTH(DEPTH), .WIDTH(EW)) u_ram (
      .clk   (clk),
      .we    (capture),
      .waddr (wr_ptr_reg),
      .wdata (wr_entry),
      .raddr (rd_ptr_reg),
      .rdata (rd_entry)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (arm) begin
         state_next = ARMED;
      end else begin
         case (state_reg)
            ARMED: begin
               if (stop)          state_next = DONE;
               else if (trig_hit) state_next = (POST_TRIG == 0) ? DONE : POST;
            end
            POST: begin
               if (stop || (capture && post_cnt_reg == CW'(1))) state_next = DONE;
            end
            DONE: begin
               if (count_reg == '0 || (pop && count_reg == CW'(1))) state_next = IDLE;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      wr_ptr_next    = wr_ptr_reg;
      rd_ptr_next    = rd_ptr_reg;
      count_next     = count_reg;
      post_cnt_next  = post_cnt_reg;
      triggered_next = triggered_reg;
      wrapped_next   = wrapped_reg;
      if (arm) begin
         wr_ptr_next    = '0;
         count_next     = '0;
         triggered_next = 1'b0;
         wrapped_next   = 1'b0;
      end else begin
         if (capture) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
            if (full) wrapped_next = 1'b1;
            else      count_next   = count_reg + CW'(1);
         end
         // A trigger coinciding with stop still records the match.
         if (trig_hit) begin
            triggered_next = 1'b1;
            post_cnt_next  = CW'(POST_TRIG);
         end else if (state_reg == POST && capture) begin
            post_cnt_next = post_cnt_reg - CW'(1);
         end
         if (pop) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
            count_next  = count_reg - CW'(1);
         end
         // Oldest entry sits count slots behind the write pointer; a full
         // buffer (count==DEPTH) wraps to wr_ptr itself.
         if (state_next == DONE && state_reg != DONE)
            rd_ptr_next = wr_ptr_next - count_next[AW-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         post_cnt_reg  <= '0;
         triggered_reg <= 1'b0;
         wrapped_reg   <= 1'b0;
      end else begin
         wr_ptr_reg    <= wr_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         count_reg     <= count_next;
         post_cnt_reg  <= post_cnt_next;
         triggered_reg <= triggered_next;
         wrapped_reg   <= wrapped_next;
      end
   end

   always_comb begin
      busy     = (state_reg == ARMED) || (state_reg == POST);
      rd_valid = (state_reg == DONE) && (count_reg != '0);
      rd_data  = rd_valid ? rd_entry : '0;
   end

   assign triggered = triggered_reg;
   assign wrapped   = wrapped_reg;

endmodule

// File: tb/tb_trace_buffer.sv
// Directed-plus-random bench for trace_buffer (POST_TRIG=4 and POST_TRIG=0
// instances side by side) against a queue-style reference model.
module tb_trace_buffer;
   import trace_pkg::*;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int EW    = ENTRY_W(DW);
   localparam int S_IDLE = 0, S_ARMED = 1, S_POST = 2, S_DONE = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          enable = 1'b0, reg_write = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
   logic          arm = 1'b0, stop = 1'b0, trig_en = 1'b0, rd_ready = 1'b0;
   logic [DW-1:0] pc = '0, inst = '0, result = '0, trig_pc = '0;

   logic          rd_valid [2];
   logic          busy [2];
   logic          triggered [2];
   logic          wrapped [2];
   logic [EW-1:0] rd_data [2];

   int compared = 0;
   int mismatched = 0;

   // Reference model: mq[i][0] is always the oldest entry.
   int            ms [2];
   int            mn [2];
   int            mpost [2];
   bit            mtrig [2];
   bit            mwrap [2];
   logic [EW-1:0] mq [2][DEPTH];
   int            pt [2] = '{4, 0};

   always #5 clk = ~clk;

   trace_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .POST_TRIG(4)) dut (
      .clk(clk), .reset(reset), .enable(enable), .pc(pc), .inst(inst), .result(result),
      .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
      .arm(arm), .stop(stop), .trig_en(trig_en), .trig_pc(trig_pc),
      .rd_valid(rd_valid[0]), .rd_ready(rd_ready), .rd_data(rd_data[0]),
      .busy(busy[0]), .triggered(triggered[0]), .wrapped(wrapped[0])
   );

   trace_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .POST_TRIG(0)) dut0 (
      .clk(clk), .reset(reset), .enable(enable), .pc(pc), .inst(inst), .result(result),
      .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
      .arm(arm), .stop(stop), .trig_en(trig_en), .trig_pc(trig_pc),
      .rd_valid(rd_valid[1]), .rd_ready(rd_ready), .rd_data(rd_data[1]),
      .busy(busy[1]), .triggered(triggered[1]), .wrapped(wrapped[1])
   );

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         ms[i] = S_IDLE; mn[i] = 0; mpost[i] = 0; mtrig[i] = 0; mwrap[i] = 0;
      end
   endtask

   task automatic pop_front(input int i);
      for (int j = 0; j < DEPTH - 1; j++) mq[i][j] = mq[i][j+1];
      mn[i]--;
   endtask

   task automatic model_step(input int i);
      logic [EW-1:0] e;
      bit cap, hit;
      e = {pc, inst, result, reg_write, mem_read, mem_write};
      if (arm) begin
         mn[i] = 0; mtrig[i] = 0; mwrap[i] = 0; ms[i] = S_ARMED;
         return;
      end
      cap = (ms[i] == S_ARMED || ms[i] == S_POST) && enable;
      if (cap) begin
         if (mn[i] == DEPTH) begin
            pop_front(i);
            mwrap[i] = 1;
         end
         mq[i][mn[i]] = e;
         mn[i]++;
      end
      case (ms[i])
         S_ARMED: begin
            hit = cap && trig_en && (pc == trig_pc);
            if (hit) mtrig[i] = 1;
            if (stop) ms[i] = S_DONE;
            else if (hit) begin
               ms[i] = (pt[i] == 0) ? S_DONE : S_POST;
               mpost[i] = pt[i];
            end
         end
         S_POST: begin
            if (cap) mpost[i]--;
            if (stop || (cap && mpost[i] == 0)) ms[i] = S_DONE;
         end
         S_DONE: begin
            if (mn[i] != 0 && rd_ready) begin
               $display("pop   dut%0d pc=%02h", i, mq[i][0][PC_LSB(DW) +: DW]);
               pop_front(i);
            end
            if (mn[i] == 0) ms[i] = S_IDLE;
         end
         default: ;
      endcase
   endtask

   task automatic check(input int i);
      bit            ev, eb;
      logic [EW-1:0] ed;
      ev = (ms[i] == S_DONE) && (mn[i] != 0);
      eb = (ms[i] == S_ARMED) || (ms[i] == S_POST);
      ed = ev ? mq[i][0] : '0;
      compared++;
      assert (rd_valid[i] === ev) else begin
         mismatched++;
         $error("FAIL rd_valid[%0d] observed=%0b expected=%0b t=%0t", i, rd_valid[i], ev, $time);
      end
      compared++;
      assert (rd_data[i] === ed) else begin
         mismatched++;
         $error("FAIL rd_data[%0d] observed=%h expected=%h t=%0t", i, rd_data[i], ed, $time);
      end
      compared++;
      assert (busy[i] === eb) else begin
         mismatched++;
         $error("FAIL busy[%0d] observed=%0b expected=%0b t=%0t", i, busy[i], eb, $time);
      end
      compared++;
      assert (triggered[i] === mtrig[i]) else begin
         mismatched++;
         $error("FAIL triggered[%0d] observed=%0b expected=%0b t=%0t", i, triggered[i], mtrig[i], $time);
      end
      compared++;
      assert (wrapped[i] === mwrap[i]) else begin
         mismatched++;
         $error("FAIL wrapped[%0d] observed=%0b expected=%0b t=%0t", i, wrapped[i], mwrap[i], $time);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      check(0);
      check(1);
   endtask

   task automatic do_arm();
      arm = 1'b1; enable = 1'b0;
      cycle();
      arm = 1'b0;
   endtask

   task automatic run(input int n, input int pc0, input bit toggle, input bit rdy);
      for (int k = 0; k < n; k++) begin
         pc = DW'(pc0 + k);
         enable = toggle ? (k % 2 == 0) : 1'b1;
         inst = DW'($urandom);
         result = DW'($urandom);
         {reg_write, mem_read, mem_write} = 3'($urandom);
         rd_ready = rdy;
         cycle();
      end
   endtask

   initial begin
      model_reset();
      @(posedge clk); #1;
      check(0); check(1);
      reset = 1'b1;

      // Basic trigger at PC 0x08
      trig_en = 1'b1; trig_pc = 8'h08;
      do_arm();
      run(35, 0, 1'b0, 1'b1);

      // Wrap: trigger at 0x20, buffer keeps the last 16 captures
      trig_pc = 8'h20;
      do_arm();
      run(60, 0, 1'b0, 1'b1);

      // Enable gating
      trig_pc = 8'h08;
      do_arm();
      run(40, 0, 1'b1, 1'b1);

      // Stop before any capture
      enable = 1'b0;
      do_arm();
      stop = 1'b1; enable = 1'b0;
      cycle();
      stop = 1'b0;
      for (int k = 0; k < 4; k++) cycle();

      // Backpressure, arm mid-drain, async reset in POST
      trig_pc = 8'h08;
      do_arm();
      run(20, 0, 1'b0, 1'b0);
      run(3, 20, 1'b0, 1'b1);
      rd_ready = 1'b0;
      do_arm();
      run(10, 0, 1'b0, 1'b0);
      #2 reset = 1'b0;
      #1;
      model_reset();
      check(0); check(1);
      @(posedge clk); #1;
      check(0); check(1);
      reset = 1'b1;
      run(4, 0, 1'b0, 1'b1);

      // Trigger and stop in the same cycle
      trig_pc = 8'h05;
      do_arm();
      run(5, 0, 1'b0, 1'b1);
      stop = 1'b1;
      run(1, 5, 1'b0, 1'b1);
      stop = 1'b0;
      run(20, 6, 1'b0, 1'b1);

      // Randomized traffic
      trig_pc = DW'($urandom_range(0, 15));
      for (int k = 0; k < 3000; k++) begin
         arm      = ($urandom_range(0, 63) == 0);
         stop     = ($urandom_range(0, 31) == 0);
         enable   = ($urandom_range(0, 3) != 0);
         trig_en  = ($urandom_range(0, 7) != 0);
         pc       = DW'($urandom_range(0, 31));
         inst     = DW'($urandom);
         result   = DW'($urandom);
         {reg_write, mem_read, mem_write} = 3'($urandom);
         rd_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      arm = 1'b0; stop = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
